// File: rtl/adc_chan_seq_pkg.sv
// Shared types for the ADC channel sequencer: FSM states, channel-index width, sample record.
package adc_chan_seq_pkg;

  localparam int ADC_CHANNELS = 2;
  localparam int ADC_DATAW    = 10;

  // Channel index width; a single channel still needs one bit.
  function automatic int cw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ADC_CW = cw_of(ADC_CHANNELS);

  typedef enum logic [2:0] {
    ST_PD,
    ST_PWRUP,
    ST_SEL,
    ST_HOLD,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic [ADC_CW-1:0]    chn;
    logic [ADC_DATAW-1:0] data;
  } sample_t;

endpackage

// File: rtl/adc_chan_seq_pick.sv
// Masked round-robin finder: first enabled channel at or after ptr, wrapping.
// Combinational, no latency; no flow control.
module adc_chan_seq_pick
  import adc_chan_seq_pkg::*;
#(
  parameter int  NumChannels = ADC_CHANNELS,
  localparam int CW          = cw_of(NumChannels)
) (
  input  logic [CW-1:0]          ptr,
  input  logic [NumChannels-1:0] mask,
  output logic [CW-1:0]          idx,
  output logic                   found
);

  logic [CW-1:0] cand;

  // Scan from the far end so the candidate nearest ptr is written last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = NumChannels - 1; i >= 0; i--) begin
      cand = CW'((int'(ptr) + i) % NumChannels);
      if (mask[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_chan_seq.sv
// Round-robin ADC channel sequencer; `ADC_CHAN_SEQ_AVG_EN reports the rounded mean of two back-to-back conversions.
// Latency: result strobe to sample_valid_o is 1 cycle (the second strobe when averaging).
// Backpressure: the sample is held with the channel select idle until sample_ready_i; no new conversion starts meanwhile.
module adc_chan_seq
  import adc_chan_seq_pkg::*;
#(
  parameter int  NumChannels   = ADC_CHANNELS,
  parameter int  DataW         = ADC_DATAW,
  parameter int  PwrUpCycles   = 16,
  parameter int  TimeoutCycles = 255,
  localparam int CW            = cw_of(NumChannels)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic [NumChannels-1:0] chn_mask_i,
  output logic                   adc_pd_o,
  output logic [NumChannels-1:0] adc_chnsel_o,
  input  logic [DataW-1:0]       adc_d_i,
  input  logic                   adc_d_val_i,
  output logic                   sample_valid_o,
  input  logic                   sample_ready_i,
  output logic [CW-1:0]          sample_chn_o,
  output logic [DataW-1:0]       sample_data_o,
  output logic                   timeout_o
);

  localparam int CntMax = (PwrUpCycles > TimeoutCycles) ? PwrUpCycles : TimeoutCycles;
  localparam int CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] PwrUpLast   = CntW'(PwrUpCycles - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);

  state_e        state;
  logic [CW-1:0] ptr;
  logic [CW-1:0] chosen;
  logic [CntW-1:0] cnt;

  logic [CW-1:0] pick_ptr;
  logic [CW-1:0] pick_idx;
  logic          pick_found;

  function automatic logic [CW-1:0] inc_chn(input logic [CW-1:0] c);
    return (int'(c) == NumChannels - 1) ? '0 : c + 1'b1;
  endfunction

  function automatic logic [NumChannels-1:0] onehot(input logic [CW-1:0] c);
    return NumChannels'(1) << c;
  endfunction

  // In GAP the search starts just past the channel that was served.
  assign pick_ptr = (state == ST_GAP) ? inc_chn(chosen) : ptr;

  adc_chan_seq_pick #(
    .NumChannels(NumChannels)
  ) u_pick (
    .ptr  (pick_ptr),
    .mask (chn_mask_i),
    .idx  (pick_idx),
    .found(pick_found)
  );

`ifdef ADC_CHAN_SEQ_AVG_EN
  logic             second;
  logic [DataW-1:0] first_d;
  logic [DataW:0]   avg_sum;

  assign avg_sum = {1'b0, first_d} + {1'b0, adc_d_i} + 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= ST_PD;
      ptr            <= '0;
      chosen         <= '0;
      cnt            <= '0;
      adc_pd_o       <= 1'b1;
      adc_chnsel_o   <= '0;
      sample_valid_o <= 1'b0;
      sample_chn_o   <= '0;
      sample_data_o  <= '0;
      timeout_o      <= 1'b0;
`ifdef ADC_CHAN_SEQ_AVG_EN
      second         <= 1'b0;
      first_d        <= '0;
`endif
    end else begin
      timeout_o <= 1'b0;
      if (!enable_i) begin
        // Pointer survives a disable so the next run resumes where it stopped.
        state          <= ST_PD;
        cnt            <= '0;
        adc_pd_o       <= 1'b1;
        adc_chnsel_o   <= '0;
        sample_valid_o <= 1'b0;
        sample_chn_o   <= '0;
        sample_data_o  <= '0;
`ifdef ADC_CHAN_SEQ_AVG_EN
        second         <= 1'b0;
`endif
      end else begin
        case (state)
          ST_PD: begin
            if (|chn_mask_i) begin
              cnt      <= '0;
              adc_pd_o <= 1'b0;
              state    <= ST_PWRUP;
            end
          end
          ST_PWRUP: begin
            if (cnt == PwrUpLast) begin
              cnt <= '0;
              if (pick_found) begin
                chosen       <= pick_idx;
                adc_chnsel_o <= onehot(pick_idx);
                state        <= ST_SEL;
              end else begin
                adc_pd_o <= 1'b1;
                state    <= ST_PD;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_SEL: begin
            // A strobe on the last allowed cycle beats the timeout.
            if (adc_d_val_i) begin
              adc_chnsel_o <= '0;
              cnt          <= '0;
`ifdef ADC_CHAN_SEQ_AVG_EN
              if (!second) begin
                first_d <= adc_d_i;
                second  <= 1'b1;
                state   <= ST_GAP;
              end else begin
                second         <= 1'b0;
                sample_valid_o <= 1'b1;
                sample_chn_o   <= chosen;
                sample_data_o  <= avg_sum[DataW:1];
                state          <= ST_HOLD;
              end
`else
              sample_valid_o <= 1'b1;
              sample_chn_o   <= chosen;
              sample_data_o  <= adc_d_i;
              state          <= ST_HOLD;
`endif
            end else if (cnt == TimeoutLast) begin
              adc_chnsel_o <= '0;
              cnt          <= '0;
              timeout_o    <= 1'b1;
              state        <= ST_GAP;
`ifdef ADC_CHAN_SEQ_AVG_EN
              second       <= 1'b0;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_HOLD: begin
            if (sample_ready_i) begin
              sample_valid_o <= 1'b0;
              state          <= ST_GAP;
            end
          end
          ST_GAP: begin
`ifdef ADC_CHAN_SEQ_AVG_EN
            if (second) begin
              if (|chn_mask_i) begin
                adc_chnsel_o <= onehot(chosen);
                state        <= ST_SEL;
              end else begin
                second        <= 1'b0;
                adc_pd_o      <= 1'b1;
                sample_chn_o  <= '0;
                sample_data_o <= '0;
                state         <= ST_PD;
              end
            end else begin
`else
            begin
`endif
              ptr <= inc_chn(chosen);
              if (pick_found) begin
                chosen       <= pick_idx;
                adc_chnsel_o <= onehot(pick_idx);
                state        <= ST_SEL;
              end else begin
                adc_pd_o      <= 1'b1;
                sample_chn_o  <= '0;
                sample_data_o <= '0;
                state         <= ST_PD;
              end
            end
          end
          default: state <= ST_PD;
        endcase
      end
    end
  end

endmodule
